instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Front-end fetch stage that drives the packed `fetch_instr_pc` bus consumed by the decode stage. It owns the program counter, issues sequential word reads to a synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. It honours decode back-pressure (stall) and flushes on an accepted jump redirect from decode.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction field driven while the queue is empty.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `imem_req`  out  1  read request to instruction memory this cycle.
- `imem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `imem_rdata`  in  32  read data; valid exactly one cycle after an accepted `imem_req`.
- `decode_stall`  in  1  decode cannot accept the current head entry.
- `jaccept`  in  1  decode resolved a taken jump/branch this cycle.
- `jaddr`  in  32  redirect target; valid when `jaccept`=1.
- `fetch_instr_pc`  out  64  head entry as {instr[63:32], pc[31:0]}.
- `fetch_valid`  out  1  head entry valid.

## Operation
- State: `pc` (next address to request), `req_q`/`pc_q` (one in-flight read and its address), and a FIFO of `DEPTH` × 64 bits with read/write pointers and `count` (0..DEPTH).
- Request: `imem_req` = !`jaccept` && (`count` + `req_q` < `DEPTH`). `imem_addr` = `pc`. When `imem_req`=1, `pc` <= `pc` + 4 (32-bit wrap: 32'hFFFF_FFFC + 4 = 0), `req_q` <= 1 and `pc_q` <= `pc`; otherwise `req_q` <= 0.
- Return: when `req_q`=1 and `jaccept`=0, push {`imem_rdata`, `pc_q`}.
- Pop: when `fetch_valid`=1 and `decode_stall`=0.
- Output: `fetch_valid` = (`count` != 0). `fetch_instr_pc` = head entry when valid; otherwise {`NOP_INSTR`, 32'h0}.
- Redirect (`jaccept`=1): `count` <= 0, pointers <= 0, `req_q` <= 0 (the in-flight response is discarded), `pc` <= {`jaddr`[31:2], 2'b00}, and no request is issued in that cycle. It overrides push, pop, and stall in the same cycle.
- Ordering: entries leave in request order. Each PC is 4 greater than the previous PC except across a redirect.
- Overflow is impossible by construction because in-flight reads reserve a slot. Push and pop in the same cycle leave `count` unchanged.

## Timing
- Reset values: `pc`=`RESET_PC`, `count`=0, `req_q`=0, `fetch_valid`=0, `fetch_instr_pc`={`NOP_INSTR`, 32'h0}, `imem_req`=1 only once `rst` is low (combinational from state; forced to 0 while `rst`=1).
- Asserting reset mid-operation clears everything immediately. The in-flight response is dropped.
- Cycle 0 is the first cycle after reset release: request at `RESET_PC`. `imem_rdata` is valid in cycle 1 and pushed at the end of cycle 1. `fetch_valid`=1 from cycle 2, so request-to-valid latency is 2 cycles.
- Sustained throughput is 1 entry/cycle when `decode_stall`=0.
- Redirect with `jaccept`=1 in cycle T: `fetch_valid`=0 in T+1. Request to the target in T+1, target entry visible in T+3.
- While `decode_stall`=1, the head and `fetch_instr_pc` are stable. Requests continue until `count` + `req_q` = `DEPTH`, then stop.

## Test plan
- Reset with `RESET_PC`=0; memory returns 32'h0001_4137 at addr 0 and 32'h0000_0013 at addr 4; no stall. Required: in cycle 2 `fetch_instr_pc`=64'h0001_4137_0000_0000, `fetch_valid`=1. In cycle 3 `fetch_instr_pc`=64'h0000_0013_0000_0004.
- Hold `decode_stall`=1 from cycle 0. Required: exactly 4 `imem_req` pulses (addrs 0, 4, 8, 12), then `imem_req`=0, and the head stays at pc 0. Release the stall. Required: pcs 0, 4, 8, 12 drain on consecutive cycles, with requests resuming at 16.
- While streaming, pulse `jaccept` with `jaddr`=32'h0000_0102. Required: `fetch_valid`=0 the next cycle, no stale pc emitted, next `imem_addr`=32'h0000_0100, and the first valid entry has pc 32'h0000_0100.
- `jaccept` together with `decode_stall`=1 and a full queue. Required: the queue is flushed and the stall is ignored for the flush.
- `RESET_PC`=32'hFFFF_FFF8, no stall. Required: emitted pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` for one cycle mid-stream with a request in flight. Required: `fetch_valid` drops immediately, the in-flight data is never emitted, and the first output after reset has pc `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus bundle.
//   master (fetch stage): drives imem_req/imem_addr toward instruction memory
//                         and fetch_instr_pc/fetch_valid toward decode.
//   slave  (environment): drives imem_rdata from memory and
//                         decode_stall/jaccept/jaddr from decode.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        decode_stall;
    logic        jaccept;
    logic [31:0] jaddr;
    logic [63:0] fetch_instr_pc;
    logic        fetch_valid;

    modport master (
        output imem_req, imem_addr, fetch_instr_pc, fetch_valid,
        input  imem_rdata, decode_stall, jaccept, jaddr
    );

    modport slave (
        input  imem_req, imem_addr, fetch_instr_pc, fetch_valid,
        output imem_rdata, decode_stall, jaccept, jaddr
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the PC, issues sequential word reads to a
// one-cycle synchronous instruction memory and buffers {instr, pc} pairs in a
// DEPTH-entry FIFO for decode. Honours decode stall; flushes on jaccept.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_queue_if.master (imem request/response, decode side)
module instr_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_queue_if.master   bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]  r_pc;
    logic [31:0]  r_pc_q;
    logic         r_req_q;
    logic [63:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]  r_count;

    logic [AW:0]  w_occ;
    logic         w_req;
    logic         w_push;
    logic         w_pop;
    logic         w_valid;

    // An in-flight read reserves a FIFO slot, so the queue can never overflow.
    assign w_occ   = r_count + {{AW{1'b0}}, r_req_q};
    assign w_valid = (r_count != '0);
    assign w_req   = !rst && !bus.jaccept && (w_occ < (AW+1)'(DEPTH));
    assign w_push  = r_req_q && !bus.jaccept;
    assign w_pop   = w_valid && !bus.decode_stall && !bus.jaccept;

    assign bus.imem_req       = w_req;
    assign bus.imem_addr      = r_pc;
    assign bus.fetch_valid    = w_valid;
    assign bus.fetch_instr_pc = w_valid ? r_mem[r_rd_ptr] : {NOP_INSTR, 32'h0000_0000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_pc_q   <= '0;
            r_req_q  <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.jaccept) begin
            // Redirect wins over push/pop/stall; the in-flight response is dropped.
            r_pc     <= {bus.jaddr[31:2], 2'b00};
            r_req_q  <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_req_q <= w_req;
            if (w_req) begin
                r_pc   <= r_pc + 32'd4;
                r_pc_q <= r_pc;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.imem_rdata, r_pc_q};
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_fetch_queue_if bus1();
    instr_fetch_queue_if bus2();

    instr_fetch_queue u_dut (.clk(clk), .rst(rst), .bus(bus1));
    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0001_4137;
        if (a == 32'h4) return 32'h0000_0013;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Synchronous instruction memories: data one cycle after the request.
    always @(posedge clk) begin
        if (bus1.imem_req) bus1.imem_rdata <= memf(bus1.imem_addr);
        if (bus2.imem_req) bus2.imem_rdata <= memf(bus2.imem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model for DUT 1: queue of {instr, pc} entries plus one
    // outstanding read, updated from the architectural rules each clock.
    logic [63:0] mq[$];
    int          m_infl = 0;
    logic [31:0] m_ipc = '0;
    logic [31:0] m_pc = '0;
    bit          m_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_infl = 0;
            m_pc   = 32'h0;
        end else if (bus1.jaccept) begin
            mq.delete();
            m_infl = 0;
            m_pc   = {bus1.jaddr[31:2], 2'b00};
        end else begin
            m_req = (mq.size() + m_infl) < 4;
            if (mq.size() != 0 && !bus1.decode_stall) void'(mq.pop_front());
            if (m_infl != 0) mq.push_back({memf(m_ipc), m_ipc});
            m_infl = m_req ? 1 : 0;
            if (m_req) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_req;
        logic        e_valid;
        logic [63:0] e_out;
        e_req   = !rst && !bus1.jaccept && ((mq.size() + m_infl) < 4);
        e_valid = !rst && (mq.size() != 0);
        e_out   = e_valid ? mq[0] : {32'h0000_0013, 32'h0};
        chk("model_imem_req", 64'(bus1.imem_req), 64'(e_req));
        if (e_req) chk("model_imem_addr", 64'(bus1.imem_addr), 64'(m_pc));
        chk("model_fetch_valid", 64'(bus1.fetch_valid), 64'(e_valid));
        chk("model_fetch_instr_pc", bus1.fetch_instr_pc, e_out);
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic st);
        rst = 1'b1;
        bus1.jaccept = 1'b0;
        bus1.decode_stall = st;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        int          npulse;
        logic [31:0] addrs[$];
        logic [31:0] first_addr;
        bit          got_first;

        bus1.decode_stall = 1'b0;
        bus1.jaccept      = 1'b0;
        bus1.jaddr        = '0;
        bus2.decode_stall = 1'b0;
        bus2.jaccept      = 1'b0;
        bus2.jaddr        = '0;

        // Reset state
        nxt();
        mid();
        chk("reset_valid", 64'(bus1.fetch_valid), 64'd0);
        chk("reset_req", 64'(bus1.imem_req), 64'd0);
        chk("reset_out", bus1.fetch_instr_pc, 64'h0000_0013_0000_0000);
        nxt();
        rst = 1'b0;

        // Basic latency: cycle 0 request, cycle 2 valid
        mid();
        chk("c0_req", 64'(bus1.imem_req), 64'd1);
        chk("c0_addr", 64'(bus1.imem_addr), 64'd0);
        chk("c0_valid", 64'(bus1.fetch_valid), 64'd0);
        nxt(); mid();
        chk("c1_valid", 64'(bus1.fetch_valid), 64'd0);
        nxt(); mid();
        chk("c2_valid", 64'(bus1.fetch_valid), 64'd1);
        chk("c2_out", bus1.fetch_instr_pc, 64'h0001_4137_0000_0000);
        nxt(); mid();
        chk("c3_out", bus1.fetch_instr_pc, 64'h0000_0013_0000_0004);
        nxt();

        // Stall from cycle 0: exactly four requests, head held at pc 0
        do_reset(1'b1);
        npulse = 0;
        addrs.delete();
        for (int i = 0; i < 10; i++) begin
            mid();
            if (bus1.imem_req) begin
                npulse++;
                addrs.push_back(bus1.imem_addr);
            end
            if (i >= 2) chk("stall_head", bus1.fetch_instr_pc, 64'h0001_4137_0000_0000);
            nxt();
        end
        chk("stall_pulses", 64'(npulse), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < addrs.size()) chk("stall_addr", 64'(addrs[i]), 64'(4 * i));
        bus1.decode_stall = 1'b0;
        got_first = 1'b0;
        first_addr = '1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("drain_valid", 64'(bus1.fetch_valid), 64'd1);
            chk("drain_pc", 64'(bus1.fetch_instr_pc[31:0]), 64'(4 * i));
            if (bus1.imem_req && !got_first) begin
                got_first = 1'b1;
                first_addr = bus1.imem_addr;
            end
            nxt();
        end
        chk("resume_addr", 64'(first_addr), 64'h10);

        // Redirect while streaming
        for (int i = 0; i < 3; i++) nxt();
        bus1.jaccept = 1'b1;
        bus1.jaddr   = 32'h0000_0102;
        mid();
        chk("jmp_T_req", 64'(bus1.imem_req), 64'd0);
        nxt();
        bus1.jaccept = 1'b0;
        mid();
        chk("jmp_T1_valid", 64'(bus1.fetch_valid), 64'd0);
        chk("jmp_T1_req", 64'(bus1.imem_req), 64'd1);
        chk("jmp_T1_addr", 64'(bus1.imem_addr), 64'h100);
        nxt(); mid();
        chk("jmp_T2_valid", 64'(bus1.fetch_valid), 64'd0);
        nxt(); mid();
        chk("jmp_T3_valid", 64'(bus1.fetch_valid), 64'd1);
        chk("jmp_T3_out", bus1.fetch_instr_pc, 64'hC0DE_0100_0000_0100);
        nxt();

        // Redirect with a full, stalled queue
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) nxt();
        mid();
        chk("full_req", 64'(bus1.imem_req), 64'd0);
        chk("full_valid", 64'(bus1.fetch_valid), 64'd1);
        nxt();
        bus1.jaccept = 1'b1;
        bus1.jaddr   = 32'h0000_0200;
        nxt();
        bus1.jaccept = 1'b0;
        mid();
        chk("flush_valid", 64'(bus1.fetch_valid), 64'd0);
        chk("flush_addr", 64'(bus1.imem_addr), 64'h200);
        nxt(); nxt(); mid();
        chk("flush_T3_out", bus1.fetch_instr_pc, 64'hC0DE_0200_0000_0200);
        nxt();
        bus1.decode_stall = 1'b0;
        for (int i = 0; i < 6; i++) nxt();

        // Reset mid-stream with a read in flight
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(bus1.fetch_valid), 64'd0);
        chk("rst_mid_req", 64'(bus1.imem_req), 64'd0);
        chk("rst_mid_out", bus1.fetch_instr_pc, 64'h0000_0013_0000_0000);
        nxt();
        rst = 1'b0;
        mid();
        chk("rst_c0_valid", 64'(bus1.fetch_valid), 64'd0);
        nxt(); mid();
        chk("rst_c1_valid", 64'(bus1.fetch_valid), 64'd0);
        nxt(); mid();
        chk("rst_c2_out", bus1.fetch_instr_pc, 64'h0001_4137_0000_0000);
        nxt();

        // PC wrap on second instance
        rst2 = 1'b0;
        mid();
        chk("wrap_c0_addr", 64'(bus2.imem_addr), 64'hFFFF_FFF8);
        nxt(); nxt(); mid();
        chk("wrap_c2_addr", 64'(bus2.imem_addr), 64'h0);
        chk("wrap_c2_out", bus2.fetch_instr_pc, 64'hC0DE_FFF8_FFFF_FFF8);
        nxt(); mid();
        chk("wrap_c3_out", bus2.fetch_instr_pc, 64'hC0DE_FFFC_FFFF_FFFC);
        nxt(); mid();
        chk("wrap_c4_out", bus2.fetch_instr_pc, 64'h0001_4137_0000_0000);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
